// File: rtl/interpolate_grad_scatter.sv
// Trilinear backward scatter: one upstream gradient -> 8 weighted corner beats.
// Build option SCATTER_ROUND_EN: round half up instead of floor on the scale shift.
module interpolate_grad_scatter #(
  parameter int FRAC_W = 8,
  parameter int GRAD_W = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FRAC_W-1:0]        frac_x,
  input  logic [FRAC_W-1:0]        frac_y,
  input  logic [FRAC_W-1:0]        frac_z,
  input  logic signed [GRAD_W-1:0] grad_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_corner,
  output logic signed [GRAD_W-1:0] out_grad,
  output logic                     out_last
);

  localparam int AW = FRAC_W + 1;
  localparam int XW = 2*FRAC_W + 2;
  localparam int WW = 3*FRAC_W + 3;
  localparam int SH = 3*FRAC_W;
  localparam int PW = GRAD_W + WW + 1;
  localparam logic [AW-1:0] ONE = AW'(1) << FRAC_W;
`ifdef SCATTER_ROUND_EN
  localparam logic [PW-1:0] HALF = PW'(1) << (SH-1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    CALC_XY,
    CALC_XYZ,
    EMIT
  } state_t;

  state_t                   state;
  logic [FRAC_W-1:0]        fx;
  logic [FRAC_W-1:0]        fy;
  logic [FRAC_W-1:0]        fz;
  logic signed [GRAD_W-1:0] g;
  logic [XW-1:0]            wxy [4];
  logic [WW-1:0]            w   [8];
  logic [2:0]               cnt;
  logic [2:0]               nxt;

  logic [AW-1:0] ax [2];
  logic [AW-1:0] ay [2];
  logic [AW-1:0] az [2];
  logic [WW-1:0] wc [8];

  always_comb begin
    ax[0] = ONE - {1'b0, fx};
    ax[1] = {1'b0, fx};
    ay[0] = ONE - {1'b0, fy};
    ay[1] = {1'b0, fy};
    az[0] = ONE - {1'b0, fz};
    az[1] = {1'b0, fz};
    for (int c = 0; c < 8; c++) begin
      wc[c] = WW'(az[c[2]]) * WW'(wxy[c[1:0]]);
    end
  end

  assign nxt      = cnt + 3'd1;
  assign in_ready = rstn && (state == IDLE);

  // Weights never exceed 2^SH, so the shifted product always fits GRAD_W.
  function automatic logic signed [GRAD_W-1:0] scale(
    input logic signed [GRAD_W-1:0] gv,
    input logic [WW-1:0]            wv
  );
    logic signed [PW-1:0] p;
    p = gv * $signed({1'b0, wv});
`ifdef SCATTER_ROUND_EN
    p = p + $signed(HALF);
`endif
    p = p >>> SH;
    return p[GRAD_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      fx         <= '0;
      fy         <= '0;
      fz         <= '0;
      g          <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_corner <= '0;
      out_grad   <= '0;
      out_last   <= 1'b0;
      for (int j = 0; j < 4; j++) wxy[j] <= '0;
      for (int c = 0; c < 8; c++) w[c] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            fx    <= frac_x;
            fy    <= frac_y;
            fz    <= frac_z;
            g     <= grad_in;
            state <= CALC_XY;
          end
        end
        CALC_XY: begin
          for (int j = 0; j < 4; j++) begin
            wxy[j] <= XW'(ay[j[1]]) * XW'(ax[j[0]]);
          end
          state <= CALC_XYZ;
        end
        CALC_XYZ: begin
          // Corner 0 is scaled straight from the fresh weights to hit N+3.
          for (int c = 0; c < 8; c++) w[c] <= wc[c];
          cnt        <= 3'd0;
          out_valid  <= 1'b1;
          out_corner <= 3'd0;
          out_grad   <= scale(g, wc[0]);
          out_last   <= 1'b0;
          state      <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (cnt == 3'd7) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              cnt        <= nxt;
              out_corner <= nxt;
              out_grad   <= scale(g, w[nxt]);
              out_last   <= (nxt == 3'd7);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
